// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// HI/LO register stage that sits directly downstream of the sequential
// multiplier. It tracks one in-flight multiply from issue (mul_start) to the
// multiplier's finish pulse (mul_done). It then captures the 64-bit product
// into HI (bits 63:32) and LO (bits 31:0). It also serves mfhi/mflo/mthi/mtlo.
// While a multiply is outstanding it stalls any request.
//
// A watchdog returns the unit to IDLE and sets a sticky timeout flag when the
// multiplier does not finish within TIMEOUT cycles. HI/LO are left untouched
// in that case.
//
// Optional feature (macro HILO_MADD_EN):
//   Adds the mul_acc input. mul_acc is sampled together with mul_start. When it
//   was set, the capture accumulates the product ({hi,lo} + mul_y, mod 2^64)
//   instead of overwriting HI/LO.
//
// Parameters:
//   TIMEOUT   watchdog limit in WAIT cycles without mul_done (2..255)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   mul_start  in   multiply issued this cycle
//   mul_acc    in   accumulate instead of overwrite (HILO_MADD_EN only)
//   mul_done   in   multiplier finish pulse
//   mul_y      in   [63:0] product, valid with mul_done
//   mthi/mtlo  in   write wdata to HI / LO
//   wdata      in   [31:0] write data
//   mfhi/mflo  in   read HI / LO (mfhi wins if both are asserted)
//   rdata      out  [31:0] registered read data, held between reads
//   rvalid     out  one-cycle pulse, the cycle after an accepted read
//   stall      out  combinational; this cycle's request is not accepted
//   busy       out  registered; multiply outstanding
//   timeout    out  sticky watchdog flag, cleared only by reset
//   hi/lo      out  [31:0] current HI / LO registers
// -----------------------------------------------------------------------------
module hilo_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_start,
`ifdef HILO_MADD_EN
  input  logic        mul_acc,
`endif
  input  logic        mul_done,
  input  logic [63:0] mul_y,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  output logic        busy,
  output logic        timeout,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Last counter value reached in WAIT before the watchdog fires. That gives
  // TIMEOUT WAIT cycles in total, because the counter starts at 0.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] counter;
  logic [63:0] capture_value;

`ifdef HILO_MADD_EN
  logic acc_flag;

  // The carry out of the 64-bit sum is discarded. That makes the accumulate
  // modulo 2^64.
  assign capture_value = acc_flag ? ({hi, lo} + mul_y) : mul_y;
`else
  assign capture_value = mul_y;
`endif

  // A request arriving while a multiply is in flight is dropped. The requester
  // holds it until stall falls.
  assign stall = busy & (mfhi | mflo | mthi | mtlo | mul_start);

  // NOTE: every register below is updated with non-blocking assignments. The
  // reads in this block therefore see the pre-edge hi/lo values. That is
  // exactly what makes a same-cycle read return the old value, and what makes
  // a same-cycle mthi/mtlo land before a later product overwrites it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
`ifdef HILO_MADD_EN
      acc_flag <= 1'b0;
`endif
    end else begin
      rvalid <= 1'b0;

      case (state)
        IDLE: begin
          // busy is low in IDLE, so every request here is accepted.
          if (mfhi) begin
            rdata  <= hi;
            rvalid <= 1'b1;
          end else if (mflo) begin
            rdata  <= lo;
            rvalid <= 1'b1;
          end

          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;

          // mul_done seen here belongs to no tracked multiply and is ignored.
          if (mul_start) begin
            state    <= WAIT;
            busy     <= 1'b1;
            counter  <= '0;
`ifdef HILO_MADD_EN
            acc_flag <= mul_acc;
`endif
          end
        end

        WAIT: begin
          // mul_start and all register requests are stalled here.
          if (mul_done) begin
            {hi, lo} <= capture_value;
            state    <= IDLE;
            busy     <= 1'b0;
`ifdef HILO_MADD_EN
            acc_flag <= 1'b0;
`endif
          end else if (counter == LAST_COUNT) begin
            timeout  <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
`ifdef HILO_MADD_EN
            acc_flag <= 1'b0;
`endif
          end else begin
            counter <= counter + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Directed testbench for hilo_unit with the default TIMEOUT of 64.
// Inputs are driven 1 time unit after a rising edge. Registered outputs are
// checked 1 time unit after the following rising edge. The combinational stall
// output is checked before the edge in the cycle it refers to.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_start;
`ifdef HILO_MADD_EN
  logic        mul_acc;
`endif
  logic        mul_done;
  logic [63:0] mul_y;
  logic        mthi, mtlo, mfhi, mflo;
  logic [31:0] wdata;
  logic [31:0] rdata, hi, lo;
  logic        rvalid, stall, busy, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mul_start(mul_start),
`ifdef HILO_MADD_EN
    .mul_acc  (mul_acc),
`endif
    .mul_done (mul_done),
    .mul_y    (mul_y),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .mfhi     (mfhi),
    .mflo     (mflo),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .stall    (stall),
    .busy     (busy),
    .timeout  (timeout),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mul_start = 1'b0;
`ifdef HILO_MADD_EN
    mul_acc   = 1'b0;
`endif
    mul_done  = 1'b0;
    mul_y     = '0;
    mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    wdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    tick();
    tick();

    // ---- reset state ----
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);

    // ---- mfhi right after reset ----
    rst_n = 1'b1;
    mfhi  = 1'b1;
    #1 check("rd0_stall", stall, 0);
    tick();
    check("rd0_rvalid", rvalid, 1);
    check("rd0_rdata", rdata, 32'h0000_0000);
    mfhi = 1'b0;
    tick();
    check("rd0_rvalid_drop", rvalid, 0);

    // ---- multiply, mul_done in cycle 33 ----
    mul_start = 1'b1;
    tick();                         // cycle 0 edge: enter WAIT
    mul_start = 1'b0;
    check("mul_busy", busy, 1);
    mflo = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      #1 check($sformatf("mul_stall_c%0d", i), stall, 1);
      tick();
    end
    check("mul_rvalid_stalled", rvalid, 0);
    mul_done = 1'b1;
    mul_y    = 64'h0000_0001_FFFF_FFFE;
    #1 check("mul_stall_c33", stall, 1);
    tick();
    mul_done = 1'b0;
    mul_y    = '0;
    check("mul_hi", hi, 32'h0000_0001);
    check("mul_lo", lo, 32'hFFFF_FFFE);
    check("mul_busy_clr", busy, 0);
    #1 check("mul_stall_clr", stall, 0);
    tick();                         // held mflo is accepted now
    mflo = 1'b0;
    check("mul_rd_rvalid", rvalid, 1);
    check("mul_rd_rdata", rdata, 32'hFFFF_FFFE);

    // ---- mthi with mflo in the same cycle ----
    mthi = 1'b1; wdata = 32'hDEAD_BEEF; mflo = 1'b1;
    tick();
    idle_inputs();
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 32'hFFFF_FFFE);
    check("mthi_rdata", rdata, 32'hFFFF_FFFE);

    // ---- same-register read and write: the read returns the old value ----
    mthi = 1'b1; wdata = 32'hCAFE_F00D; mfhi = 1'b1;
    tick();
    idle_inputs();
    check("rw_same_rdata", rdata, 32'hDEAD_BEEF);
    check("rw_same_hi", hi, 32'hCAFE_F00D);

    // ---- mthi and mtlo together ----
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
    tick();
    idle_inputs();
    check("both_hi", hi, 32'h1234_5678);
    check("both_lo", lo, 32'h1234_5678);

    // ---- mfhi wins over mflo ----
    mtlo = 1'b1; wdata = 32'h55AA_55AA;
    tick();
    idle_inputs();
    mfhi = 1'b1; mflo = 1'b1;
    tick();
    idle_inputs();
    check("prio_rdata", rdata, 32'h1234_5678);
    tick();
    check("hold_rdata", rdata, 32'h1234_5678);
    check("hold_rvalid", rvalid, 0);

    // ---- mul_done in IDLE is ignored ----
    mul_done = 1'b1; mul_y = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle_inputs();
    check("idle_done_hi", hi, 32'h1234_5678);
    check("idle_done_lo", lo, 32'h55AA_55AA);
    check("idle_done_busy", busy, 0);

    // ---- watchdog: 64 WAIT cycles without mul_done ----
    mul_start = 1'b1;
    tick();
    // A mul_start repeated inside WAIT must not restart the counter.
    for (int i = 1; i <= 63; i++) begin
      mul_start = (i == 40);
      tick();
    end
    mul_start = 1'b0;
    check("wd_busy_63", busy, 1);
    check("wd_timeout_63", timeout, 0);
    tick();
    check("wd_busy_64", busy, 0);
    check("wd_timeout_64", timeout, 1);
    check("wd_hi", hi, 32'h1234_5678);
    check("wd_lo", lo, 32'h55AA_55AA);
    mul_done = 1'b1; mul_y = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle_inputs();
    check("late_done_hi", hi, 32'h1234_5678);
    check("late_done_lo", lo, 32'h55AA_55AA);

    // ---- a new multiply is still accepted with timeout set ----
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    check("to_restart_busy", busy, 1);
    mul_done = 1'b1; mul_y = 64'hA5A5_0000_0000_5A5A;
    tick();
    idle_inputs();
    check("to_restart_hi", hi, 32'hA5A5_0000);
    check("to_restart_lo", lo, 32'h0000_5A5A);
    check("to_sticky", timeout, 1);

    // ---- reset in the middle of WAIT ----
    mul_start = 1'b1;
    tick();                         // cycle 0
    mul_start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    rst_n = 1'b0;                   // cycle 10
    tick();
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_hi", hi, 0);
    check("mrst_lo", lo, 0);
    check("mrst_timeout", timeout, 0);
    for (int i = 11; i <= 32; i++) tick();
    mul_done = 1'b1; mul_y = 64'h1111_2222_3333_4444;   // cycle 33
    tick();
    idle_inputs();
    check("mrst_done_hi", hi, 0);
    check("mrst_done_lo", lo, 0);
    check("mrst_done_busy", busy, 0);

`ifdef HILO_MADD_EN
    // ---- multiply-accumulate ----
    mtlo = 1'b1; wdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    mul_start = 1'b1; mul_acc = 1'b1;
    tick();
    idle_inputs();
    mul_done = 1'b1; mul_y = 64'h0000_0000_0000_0001;
    tick();
    idle_inputs();
    check("madd_hi", hi, 32'h0000_0001);
    check("madd_lo", lo, 32'h0000_0000);
    mul_start = 1'b1; mul_acc = 1'b0;
    tick();
    idle_inputs();
    mul_done = 1'b1; mul_y = 64'h0000_0002_0000_0003;
    tick();
    idle_inputs();
    check("mov_hi", hi, 32'h0000_0002);
    check("mov_lo", lo, 32'h0000_0003);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- HI/LO register stage directly downstream of the sequential multiplier.
- Tracks an in-flight multiply from issue (start) to completion (finish pulse), then captures the 64-bit product into HI (bits 63:32) and LO (bits 31:0).
- Serves mfhi/mflo/mthi/mtlo for the MIPS datapath, and stalls the pipeline while a multiply is outstanding.

Parameters:
- TIMEOUT, 64: watchdog limit in cycles spent in WAIT without a finish pulse; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- mul_start  in  1  multiply issued this cycle (same signal that drives the multiplier's start)
- mul_done  in  1  multiplier finish pulse
- mul_y  in  64  multiplier product, valid when mul_done=1
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  write data for mthi/mtlo
- mfhi  in  1  read HI
- mflo  in  1  read LO
- rdata  out  32  registered read data
- rvalid  out  1  rdata valid pulse, 1 cycle after an accepted read
- stall  out  1  combinational; request not accepted this cycle
- busy  out  1  registered; multiply outstanding
- timeout  out  1  sticky watchdog flag
- hi  out  32  current HI
- lo  out  32  current LO

Behaviour:
- Reset (rst_n=0 at a clk edge): hi=0, lo=0, rdata=0, rvalid=0, busy=0, timeout=0, counter=0, state=IDLE. Reset applies in any state; it aborts an in-flight multiply and any later mul_done is ignored.
- States: IDLE, WAIT.
- IDLE + mul_start=1:
  - go to WAIT; busy=1 from the next cycle; counter=0.
  - mthi/mtlo in the same cycle are applied first; the later product overwrites them.
  - A read in the same cycle returns the pre-multiply value.
- WAIT + mul_done=1:
  - {hi,lo} <= mul_y at that edge; state goes to IDLE; busy=0 from the next cycle.
  - Capture latency: new hi/lo visible 1 cycle after the mul_done cycle.
- WAIT + mul_done=0: counter increments each cycle. When counter reaches TIMEOUT-1: timeout<=1, state goes to IDLE, busy<=0, hi/lo unchanged.
- timeout clears only on reset. A new mul_start is still accepted while timeout is set.
- mul_start while in WAIT: ignored; the state and counter are unaffected.
- mul_done while in IDLE: ignored; no change to hi/lo.
- stall = busy & (mfhi|mflo|mthi|mtlo|mul_start). While stalled the request is dropped; the requester holds it until stall=0.
- Reads, when not stalled:
  - mfhi: rdata<=hi, rvalid<=1 next cycle.
  - mflo: rdata<=lo, rvalid<=1 next cycle.
  - mfhi and mflo together: mfhi wins.
  - rdata holds its value when there is no read; rvalid=0 otherwise.
- Writes, when not stalled:
  - mthi: hi<=wdata.
  - mtlo: lo<=wdata.
  - Both asserted: both registers take wdata.
  - Read and write to the same register in one cycle: the read returns the old value.
- hi and lo are driven directly from the registers.

Optional Feature:
- Macro HILO_MADD_EN.
- Defined:
  - Adds input port mul_acc (1 bit), sampled with mul_start in IDLE and held in an internal flag.
  - On capture with the flag set: {hi,lo} <= {hi,lo} + mul_y, modulo 2^64, carry out discarded.
  - Flag clear: overwrite as normal.
  - The flag clears on capture, on timeout and on reset.
- Undefined: the port is absent and capture always overwrites.

Test Plan:
- Reset then mfhi → rdata=0x00000000 with rvalid=1 one cycle later; busy=0, timeout=0.
- mul_start; mul_done on cycle 33 with mul_y=0x00000001_FFFFFFFE → stall=1 on mflo during cycles 1–33; after capture hi=0x00000001, lo=0xFFFFFFFE, busy=0; mflo then returns 0xFFFFFFFE.
- mthi wdata=0xDEADBEEF and mflo in the same IDLE cycle → hi=0xDEADBEEF; rdata=old lo; mthi+mtlo wdata=0x12345678 → hi=lo=0x12345678.
- TIMEOUT=64, mul_start with no mul_done → timeout=1 and busy=0 after 64 WAIT cycles, hi/lo unchanged; a late mul_done with mul_y=0xFFFF... leaves hi/lo unchanged.
- rst_n=0 mid-WAIT (cycle 10) → busy=0 and hi=lo=0 next cycle; mul_done at cycle 33 is ignored.
- HILO_MADD_EN: hi:lo=0x00000000_FFFFFFFF, mul_acc=1, mul_y=0x00000000_00000001 → hi=0x00000001, lo=0x00000000; repeated with mul_acc=0 → overwrite.
